// File: rtl/cpu_consts.sv
// Shared constants for branch resolution: funct3 encodings and BHT 2-bit counter helpers.
package cpu_consts;

    localparam int unsigned F3_W  = 3;
    localparam int unsigned CTR_W = 2;

    typedef enum logic [F3_W-1:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    typedef logic [CTR_W-1:0] ctr_t;

    localparam ctr_t CTR_SNT   = 2'b00;
    localparam ctr_t CTR_WNT   = 2'b01;
    localparam ctr_t CTR_WT    = 2'b10;
    localparam ctr_t CTR_ST    = 2'b11;
    localparam ctr_t BHT_RESET = CTR_WNT;

    // 010/011 are the only encodings with no branch meaning
    function automatic logic f3_legal(input logic [F3_W-1:0] f3);
        logic legal;
        case (f3)
            3'b010, 3'b011: legal = 1'b0;
            default:        legal = 1'b1;
        endcase
        return legal;
    endfunction

    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            default: nxt = taken ? CTR_ST  : CTR_WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational conditional-branch comparator; non-branches and undefined funct3 resolve not-taken.
module branch_cmp
    import cpu_consts::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    input  logic [F3_W-1:0] funct3,
    input  logic            is_b_type,
    output logic            taken
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (opr_a == opr_b);
    assign w_lt  = ($signed(opr_a) < $signed(opr_b));
    assign w_ltu = (opr_a < opr_b);

    always_comb begin
        taken = 1'b0;
        if (is_b_type) begin
            case (funct3)
                F3_BEQ:  taken = w_eq;
                F3_BNE:  taken = !w_eq;
                F3_BLT:  taken = w_lt;
                F3_BGE:  taken = !w_lt;
                F3_BLTU: taken = w_ltu;
                F3_BGEU: taken = !w_ltu;
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage with a PC-indexed BHT of 2-bit counters and a 1-deep registered result.
// Optional macro BRANCH_PERF_CNT_EN adds saturating branch / mispredict counters.
module branch_resolve_unit
    import cpu_consts::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned IDX_LSB     = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pred_pc_i,
    output logic            pred_taken_o,
    input  logic            res_valid_i,
    output logic            res_ready_o,
    input  logic [XLEN-1:0] res_pc_i,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic            is_b_type_i,
    input  logic [F3_W-1:0] instr_funct3_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] target_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            branch_taken_o,
    output logic            mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispredict_cnt_o
`endif
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    ctr_t            r_bht [BHT_ENTRIES];
    logic            r_out_valid;
    logic            r_taken;
    logic            r_mispredict;
    logic [XLEN-1:0] r_redirect_pc;

    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_res_idx;
    logic             w_accept;
    logic             w_taken;
    logic             w_bht_we;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_unused_pc;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .opr_a     (opr_a_i),
        .opr_b     (opr_b_i),
        .funct3    (instr_funct3_i),
        .is_b_type (is_b_type_i),
        .taken     (w_taken)
    );

    // Upper PC bits alias freely into the table
    assign w_pred_idx  = pred_pc_i[IDX_LSB +: IDX_W];
    assign w_res_idx   = res_pc_i[IDX_LSB +: IDX_W];
    assign w_unused_pc = ^pred_pc_i;

    assign res_ready_o   = !r_out_valid || out_ready_i;
    assign w_accept      = res_valid_i && res_ready_o;
    assign w_bht_we      = w_accept && is_b_type_i && f3_legal(instr_funct3_i);
    assign w_redirect_pc = w_taken ? target_i : (res_pc_i + XLEN'(4));

    // Read returns the stored counter; a same-cycle update is not forwarded
    assign pred_taken_o = r_bht[w_pred_idx][CTR_W-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                r_bht[i] <= BHT_RESET;
            end
        end else if (w_bht_we) begin
            r_bht[w_res_idx] <= ctr_next(r_bht[w_res_idx], w_taken);
        end
    end

    // Flush wins over a same-cycle accept; the BHT update above still lands
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_taken       <= 1'b0;
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
        end else if (w_accept) begin
            r_taken       <= w_taken;
            r_mispredict  <= w_taken ^ pred_taken_i;
            r_redirect_pc <= w_redirect_pc;
        end
    end

    assign out_valid_o    = r_out_valid;
    assign branch_taken_o = r_taken;
    assign mispredict_o   = r_mispredict;
    assign redirect_pc_o  = r_redirect_pc;

`ifdef BRANCH_PERF_CNT_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;
    logic             w_cnt_en;

    assign w_cnt_en = w_accept && !flush_i;

    // Saturating event counters for surviving requests
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (w_cnt_en) begin
            if (is_b_type_i && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if ((w_taken ^ pred_taken_i) && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
        end
    end

    assign branch_cnt_o     = r_branch_cnt;
    assign mispredict_cnt_o = r_mispredict_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned BHT     = 64;
    localparam int unsigned IDX_LSB = 2;

    logic            clk;
    logic            resetn;
    logic            flush_i;
    logic [63:0]     pred_pc_i;
    logic            pred_taken_o;
    logic            res_valid_i;
    logic            res_ready_o;
    logic [63:0]     res_pc_i;
    logic [63:0]     opr_a_i;
    logic [63:0]     opr_b_i;
    logic            is_b_type_i;
    logic [2:0]      instr_funct3_i;
    logic            pred_taken_i;
    logic [63:0]     target_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic            branch_taken_o;
    logic            mispredict_o;
    logic [63:0]     redirect_pc_o;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0]     branch_cnt_o;
    logic [31:0]     mispredict_cnt_o;
`endif

    branch_resolve_unit #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (BHT),
        .IDX_LSB     (IDX_LSB)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush_i        (flush_i),
        .pred_pc_i      (pred_pc_i),
        .pred_taken_o   (pred_taken_o),
        .res_valid_i    (res_valid_i),
        .res_ready_o    (res_ready_o),
        .res_pc_i       (res_pc_i),
        .opr_a_i        (opr_a_i),
        .opr_b_i        (opr_b_i),
        .is_b_type_i    (is_b_type_i),
        .instr_funct3_i (instr_funct3_i),
        .pred_taken_i   (pred_taken_i),
        .target_i       (target_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .branch_taken_o (branch_taken_o),
        .mispredict_o   (mispredict_o),
        .redirect_pc_o  (redirect_pc_o)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    int          m_bht [BHT];
    bit          m_valid;
    bit          m_taken;
    bit          m_mp;
    logic [63:0] m_rd;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    function automatic bit ref_taken(input logic [63:0] a, input logic [63:0] b,
                                     input logic [2:0] f3, input bit isb);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        if (!isb) return 1'b0;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> IDX_LSB) % BHT);
    endfunction

    always @(posedge clk or negedge resetn) begin
        bit acc;
        bit t;
        int ix;
        if (!resetn) begin
            for (int i = 0; i < int'(BHT); i++) m_bht[i] = 1;
            m_valid = 0;
            m_taken = 0;
            m_mp    = 0;
            m_rd    = '0;
            m_bcnt  = '0;
            m_mcnt  = '0;
        end else begin
            acc = res_valid_i && (!m_valid || out_ready_i);
            t   = ref_taken(opr_a_i, opr_b_i, instr_funct3_i, is_b_type_i);
            if (acc) begin
                m_taken = t;
                m_mp    = t ^ pred_taken_i;
                m_rd    = t ? target_i : res_pc_i + 64'd4;
                if (is_b_type_i && instr_funct3_i != 3'd2 && instr_funct3_i != 3'd3) begin
                    ix = idx_of(res_pc_i);
                    if (t && m_bht[ix] < 3) m_bht[ix] = m_bht[ix] + 1;
                    else if (!t && m_bht[ix] > 0) m_bht[ix] = m_bht[ix] - 1;
                end
                if (!flush_i) begin
                    if (is_b_type_i && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
                    if ((t ^ pred_taken_i) && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
                end
            end
            if (flush_i) m_valid = 0;
            else if (acc) m_valid = 1;
            else if (out_ready_i) m_valid = 0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (resetn) begin
            chk("out_valid", 64'(out_valid_o), 64'(m_valid));
            chk("res_ready", 64'(res_ready_o), 64'(!m_valid || out_ready_i));
            chk("pred_taken", 64'(pred_taken_o), 64'(m_bht[idx_of(pred_pc_i)] >= 2));
            if (m_valid) begin
                chk("branch_taken", 64'(branch_taken_o), 64'(m_taken));
                chk("mispredict", 64'(mispredict_o), 64'(m_mp));
                chk("redirect_pc", redirect_pc_o, m_rd);
            end
`ifdef BRANCH_PERF_CNT_EN
            chk("branch_cnt", 64'(branch_cnt_o), 64'(m_bcnt));
            chk("mispredict_cnt", 64'(mispredict_cnt_o), 64'(m_mcnt));
`endif
        end
    end

    // One request with out_ready_i high; returns mid-cycle after the result registers
    task automatic req(input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] f3, input bit isb, input bit pt,
                       input logic [63:0] tgt, input bit fl);
        res_pc_i       = pc;
        opr_a_i        = a;
        opr_b_i        = b;
        instr_funct3_i = f3;
        is_b_type_i    = isb;
        pred_taken_i   = pt;
        target_i       = tgt;
        flush_i        = fl;
        res_valid_i    = 1'b1;
        @(posedge clk);
        #1;
        res_valid_i = 1'b0;
        flush_i     = 1'b0;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd_pc();
        int sel;
        sel = int'($urandom_range(0, 15));
        if (sel == 0) return 64'hFFFF_FFFF_FFFF_FFFC;
        if (sel == 1) return {32'($urandom), 32'($urandom)};
        return 64'($urandom_range(0, 15)) << IDX_LSB;
    endfunction

    function automatic logic [63:0] rnd_opr();
        int sel;
        sel = int'($urandom_range(0, 3));
        if (sel == 0) return 64'($urandom_range(0, 3));
        if (sel == 1) return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
        return {32'($urandom), 32'($urandom)};
    endfunction

    initial begin
        resetn = 1'b0;
        flush_i = 1'b0;
        pred_pc_i = '0;
        res_valid_i = 1'b0;
        res_pc_i = '0;
        opr_a_i = '0;
        opr_b_i = '0;
        is_b_type_i = 1'b0;
        instr_funct3_i = '0;
        pred_taken_i = 1'b0;
        target_i = '0;
        out_ready_i = 1'b1;

        #2;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_redirect", redirect_pc_o, 64'd0);
        chk("rst_pred", 64'(pred_taken_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        #1;

        // Comparator sweep at pc 0x10
        req(64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd4, 1, 0, 64'h40, 0);
        chk("blt_taken", 64'(branch_taken_o), 64'd1);
        chk("blt_mispredict", 64'(mispredict_o), 64'd1);
        chk("blt_redirect", redirect_pc_o, 64'h40);
        req(64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd6, 1, 0, 64'h40, 0);
        chk("bltu_taken", 64'(branch_taken_o), 64'd0);
        chk("bltu_redirect", redirect_pc_o, 64'h14);
        req(64'h10, 64'd5, 64'd5, 3'd5, 1, 0, 64'h40, 0);
        chk("bge_taken", 64'(branch_taken_o), 64'd1);
        req(64'h10, 64'd7, 64'd8, 3'd0, 1, 0, 64'h40, 0);
        chk("beq_taken", 64'(branch_taken_o), 64'd0);
        pred_pc_i = 64'h20;
        req(64'h20, 64'd7, 64'd7, 3'd2, 1, 1, 64'h40, 0);
        chk("f3_010_taken", 64'(branch_taken_o), 64'd0);
        chk("f3_010_mispredict", 64'(mispredict_o), 64'd1);
        chk("f3_010_pred", 64'(pred_taken_o), 64'd0);

        // Counter saturation at 0x100
        pred_pc_i = 64'h100;
        for (int i = 0; i < 4; i++) req(64'h100, 64'd3, 64'd3, 3'd0, 1, 0, 64'h500, 0);
        chk("sat_hi_pred", 64'(pred_taken_o), 64'd1);
        req(64'h100, 64'd3, 64'd4, 3'd0, 1, 1, 64'h500, 0);
        chk("sat_dec1_pred", 64'(pred_taken_o), 64'd1);
        req(64'h100, 64'd3, 64'd4, 3'd0, 1, 1, 64'h500, 0);
        req(64'h100, 64'd3, 64'd4, 3'd0, 1, 1, 64'h500, 0);
        chk("sat_lo_pred", 64'(pred_taken_o), 64'd0);

        // Mispredict / redirect
        req(64'h200, 64'd1, 64'd2, 3'd1, 1, 0, 64'h80, 0);
        chk("bne_taken", 64'(branch_taken_o), 64'd1);
        chk("bne_mispredict", 64'(mispredict_o), 64'd1);
        chk("bne_redirect", redirect_pc_o, 64'h80);
        req(64'h200, 64'd3, 64'd3, 3'd1, 1, 0, 64'h80, 0);
        chk("bne_nt_redirect", redirect_pc_o, 64'h204);
        chk("bne_nt_mispredict", 64'(mispredict_o), 64'd0);
        req(64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'd2, 3'd0, 1, 0, 64'h80, 0);
        chk("wrap_redirect", redirect_pc_o, 64'd0);

        // Flush with same-cycle accept at 0x304 (fresh index)
        pred_pc_i = 64'h304;
        req(64'h304, 64'd9, 64'd9, 3'd0, 1, 0, 64'h10, 1);
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        chk("flush_bht", 64'(pred_taken_o), 64'd1);

        // Backpressure
        out_ready_i = 1'b0;
        req(64'h40, 64'd1, 64'd1, 3'd0, 1, 1, 64'h99, 0);
        res_pc_i = 64'h40;
        opr_a_i = 64'd1;
        opr_b_i = 64'd1;
        instr_funct3_i = 3'd1;
        is_b_type_i = 1'b1;
        pred_taken_i = 1'b0;
        target_i = 64'h77;
        res_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 64'(res_ready_o), 64'd0);
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_taken", 64'(branch_taken_o), 64'd1);
            chk("bp_redirect", redirect_pc_o, 64'h99);
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        out_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 64'(res_ready_o), 64'd1);
        @(posedge clk);
        #1 res_valid_i = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_next_valid", 64'(out_valid_o), 64'd1);
        chk("bp_next_taken", 64'(branch_taken_o), 64'd0);
        chk("bp_next_redirect", redirect_pc_o, 64'h44);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            res_valid_i    = ($urandom_range(0, 3) != 0);
            res_pc_i       = rnd_pc();
            opr_a_i        = rnd_opr();
            opr_b_i        = ($urandom_range(0, 3) == 0) ? opr_a_i : rnd_opr();
            instr_funct3_i = 3'($urandom_range(0, 7));
            is_b_type_i    = ($urandom_range(0, 3) != 0);
            pred_taken_i   = 1'($urandom_range(0, 1));
            target_i       = {32'($urandom), 32'($urandom)};
            out_ready_i    = ($urandom_range(0, 3) != 0);
            flush_i        = ($urandom_range(0, 15) == 0);
            pred_pc_i      = rnd_pc();
        end

        // Reset while a result is held
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        res_valid_i = 1'b1;
        is_b_type_i = 1'b1;
        instr_funct3_i = 3'd0;
        opr_a_i = 64'd2;
        opr_b_i = 64'd2;
        target_i = 64'h1234;
        @(posedge clk);
        #1 res_valid_i = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_taken", 64'(branch_taken_o), 64'd0);
        chk("mid_rst_mispredict", 64'(mispredict_o), 64'd0);
        chk("mid_rst_redirect", redirect_pc_o, 64'd0);
`ifdef BRANCH_PERF_CNT_EN
        chk("mid_rst_bcnt", 64'(branch_cnt_o), 64'd0);
        chk("mid_rst_mcnt", 64'(mispredict_cnt_o), 64'd0);
`endif
        for (int i = 0; i < int'(BHT); i++) begin
            pred_pc_i = 64'(i) << IDX_LSB;
            #1;
            chk("mid_rst_pred", 64'(pred_taken_o), 64'd0);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the combinational branch comparator. Adds a PC-indexed branch history table (BHT) of 2-bit saturating counters for fetch-stage prediction. Adds a registered resolve stage with valid/ready handshake that computes the branch outcome, detects mispredicts and produces the redirect PC. Sits between execute and fetch; execute feeds the resolve port, fetch reads the predict port.

Parameters:
XLEN, 64, operand/PC width (32 or 64)
BHT_ENTRIES, 64, number of BHT counters; power of two, >=2
IDX_LSB, 2, lowest PC bit used for BHT index (index = pc[IDX_LSB +: log2(BHT_ENTRIES)])

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
flush_i  in  1  drop the registered result (pipeline flush)
pred_pc_i  in  XLEN  fetch PC to predict
pred_taken_o  out  1  MSB of BHT counter at pred_pc_i index (combinational read)
res_valid_i  in  1  resolve request valid
res_ready_o  out  1  resolve request accepted when valid&ready
res_pc_i  in  XLEN  PC of the instruction being resolved
opr_a_i  in  XLEN  rs1 value
opr_b_i  in  XLEN  rs2 value
is_b_type_i  in  1  instruction is a conditional branch
instr_funct3_i  in  3  branch funct3
pred_taken_i  in  1  prediction fetch used for this instruction
target_i  in  XLEN  branch target (pc+imm, computed upstream)
out_valid_o  out  1  registered result valid
out_ready_i  in  1  consumer accepts result
branch_taken_o  out  1  resolved outcome
mispredict_o  out  1  outcome differs from pred_taken_i
redirect_pc_o  out  XLEN  taken ? target : res_pc+4 (mod 2^XLEN)

Behaviour:
- Reset (async, resetn=0): out_valid_o=0, branch_taken_o=0, mispredict_o=0, redirect_pc_o=0, all BHT counters=2'b01 (weakly not-taken). Reset mid-operation discards the held result; no BHT writes while resetn=0.
- Compare: BEQ 000 eq; BNE 001 ne; BLT 100 signed lt; BGE 101 signed ge; BLTU 110 unsigned lt; BGEU 111 unsigned ge. funct3 010/011 or is_b_type_i=0 -> taken=0.
- Handshake: res_ready_o = !out_valid_o | out_ready_i. The request is accepted on res_valid_i & res_ready_o. Latency is 1 cycle: results register on accept and out_valid_o=1 next cycle. Results hold stable while out_valid_o & !out_ready_i. The consumer takes the result with no new request -> out_valid_o=0. Back-to-back accepts sustain 1 result/cycle.
- mispredict_o = taken ^ pred_taken_i for every accepted request, including non-branch requests with pred_taken_i=1.
- BHT update on accepted request with is_b_type_i=1 and a legal funct3: taken -> counter+1, saturate at 11; not taken -> counter-1, saturate at 00. The update is written at the clock edge of acceptance. No update for illegal funct3 or non-branch.
- Read/write collision at the same index in the same cycle: pred_taken_o returns the pre-update value (no bypass).
- flush_i=1: next cycle out_valid_o=0. A request accepted in the same cycle as the flush is discarded. A BHT update from that accept still commits (no rollback). flush_i has priority over accept for out_valid_o.
- PC+4 wraps modulo 2^XLEN; the upper index bits of the PC are ignored (aliasing allowed).

Optional Feature:
Macro BRANCH_PERF_CNT_EN. When defined, adds outputs branch_cnt_o[31:0] and mispredict_cnt_o[31:0]. These count accepted, non-flushed B-type requests and accepted, non-flushed mispredicts. Both saturate at 32'hFFFF_FFFF and reset to 0. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- cpu_consts package: funct3 enum (BEQ..BGEU), 2-bit counter typedef with encodings SNT=00, WNT=01, WT=10, ST=11, and the BHT reset value constant WNT.
- One sub-module, branch_cmp: combinational XLEN-parametrised comparator taking (opr_a, opr_b, funct3, is_b_type) and returning taken.
- BHT array and handshake registers live in branch_resolve_unit.

Test Plan:
- Compare sweep, XLEN=64: BLT a=64'hFFFF_FFFF_FFFF_FFFF (-1), b=1 -> taken=1. BLTU with the same operands -> taken=0. BGE a=b=5 -> taken=1. BEQ 7/8 -> 0. funct3=010 -> 0 with no BHT change.
- Counter saturation: 4 taken BEQ resolves at pc=0x100 -> counter 01->10->11->11, pred_taken_o at 0x100 is 1. Then 3 not-taken resolves -> 00, pred_taken_o=0.
- Backpressure: out_ready_i=0 with a result held -> res_ready_o=0 and outputs stable for 5 cycles. Raise out_ready_i -> a new accept in the same cycle and out_valid_o stays 1.
- Mispredict/redirect: pc=0x200, target=0x80, pred_taken_i=0, BNE 1/2 -> taken=1, mispredict=1, redirect_pc=0x80. Not-taken case -> redirect_pc=0x204. pc=64'hFFFF_FFFF_FFFF_FFFC, not taken -> redirect_pc=0.
- Flush and reset: accept and flush in the same cycle -> out_valid_o=0 next cycle, and the BHT entry still updated. Assert resetn low mid-stream -> all outputs 0 asynchronously and every pred_taken_o=0 (counters 01).
- With BRANCH_PERF_CNT_EN: 10 branches (3 mispredicted, 1 flushed non-mispredict) -> branch_cnt_o=9, mispredict_cnt_o=3.
